// File: rtl/serial_shift_unit_if.sv
// Request/result handshake bundle for serial_shift_unit.
// master = issue/writeback side, slave = the shift unit.
interface serial_shift_unit_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_ovf;

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/serial_shift_unit.sv
// Multi-cycle shifter: one 1-bit SLL/SRL/SLA/SRA step per clock, with a
// valid/ready request side and a valid/ready result side.
module serial_shift_unit #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_shift_unit_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SLA = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r, state_n;
    logic [WIDTH-1:0]   work_r, work_n;
    logic [1:0]         op_r, op_n;
    logic [CNT_W-1:0]   cnt_r, cnt_n;
    logic               ovf_r, ovf_n;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [CNT_W-1:0]   shamt_clip_s;

    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] w,
                                                    input logic [1:0]       op);
        case (op)
            OP_SLL, OP_SLA: shift_step = {w[WIDTH-2:0], 1'b0};
            OP_SRL:         shift_step = {1'b0, w[WIDTH-1:1]};
            OP_SRA:         shift_step = {w[WIDTH-1], w[WIDTH-1:1]};
            default:        shift_step = w;
        endcase
    endfunction

    // Amounts of WIDTH or more all give the same fully-shifted result.
    assign shamt_clip_s = (32'(bus.in_shamt) >= WIDTH) ? CNT_W'(WIDTH)
                                                      : CNT_W'(bus.in_shamt);

    // Next-state and datapath update.
    always_comb begin
        state_n = state_r;
        work_n  = work_r;
        op_n    = op_r;
        cnt_n   = cnt_r;
        ovf_n   = ovf_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    work_n = bus.in_data;
                    op_n   = bus.in_op;
                    cnt_n  = shamt_clip_s;
                    ovf_n  = 1'b0;
                    if (shamt_clip_s == CNT_W'(0)) begin
                        state_n = DONE;
                    end else begin
                        state_n = SHIFT;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                work_n = shift_step(work_r, op_r);
                cnt_n  = cnt_r - CNT_W'(1);
                // Sign overflow is judged on the operand before each left step.
                if ((op_r == OP_SLA) && (work_r[WIDTH-1] != work_r[WIDTH-2])) begin
                    ovf_n = 1'b1;
                end else begin
                    ovf_n = ovf_r;
                end
                if (cnt_r <= CNT_W'(1)) begin
                    state_n = DONE;
                end else begin
                    state_n = SHIFT;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, datapath and handshake-output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            work_r      <= '0;
            op_r        <= 2'b00;
            cnt_r       <= '0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            work_r      <= work_n;
            op_r        <= op_n;
            cnt_r       <= cnt_n;
            ovf_r       <= ovf_n;
            in_ready_r  <= (state_n == IDLE);
            out_valid_r <= (state_n == DONE);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = work_r;
    assign bus.out_ovf   = ovf_r;
endmodule

// File: tb/tb_serial_shift_unit.sv
// Self-checking bench for serial_shift_unit: directed scenarios plus random
// requests checked against an arithmetic reference model.
module tb_serial_shift_unit;
    localparam int W  = 8;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_shift_unit_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

    serial_shift_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Shift semantics expressed as multiplication/division on integers.
    function automatic void ref_model(input logic [7:0] d, input logic [3:0] s,
                                      input logic [1:0] op,
                                      output logic [7:0] r, output logic o);
        longint n, u, sv, p;
        n  = (s > 4'd8) ? 64'sd8 : longint'(s);
        u  = longint'(d);
        sv = longint'($signed(d));
        p  = sv * (64'sd1 << n);
        o  = 1'b0;
        case (op)
            2'd0:    r = 8'(u << n);
            2'd1:    r = 8'(u >> n);
            2'd2: begin
                r = 8'(p);
                o = (p > 64'sd127) || (p < -64'sd128);
            end
            2'd3:    r = 8'(sv >>> n);
            default: r = 8'h00;
        endcase
    endfunction

    // Issue one request (called at a negedge) and wait for out_valid.
    task automatic send_req(input logic [7:0] d, input logic [3:0] s, input logic [1:0] op,
                            output int lat, output logic [7:0] res, output logic ovf,
                            output bit to);
        int g;
        to  = 1'b0;
        lat = 0;
        res = 8'h00;
        ovf = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_op    = op;
        g = 0;
        while (!bus.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            to = 1'b1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) to = 1'b1;
        res = bus.out_data;
        ovf = bus.out_ovf;
    endtask

    task automatic finish_rsp();
        bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_shamt = 4'd0;
        bus.in_op = 2'd0; bus.out_ready = 1'b1;
        #12;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_vec++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
        n_vec++; if (bus.out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_out_ovf: got %b expected 0", bus.out_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [1:0] ops [3];
        logic [7:0] exp [3];
        int lat; logic [7:0] res; logic ovf; bit to;
        ops = '{2'd0, 2'd1, 2'd3};
        exp = '{8'h58, 8'h25, 8'hE5};
        for (int i = 0; i < 3; i++) begin
            send_req(8'h96, 4'd2, ops[i], lat, res, ovf, to);
            n_vec++; if (to) begin n_err++; $display("FAIL basic_timeout op=%0d: got timeout expected result", ops[i]); end
            n_vec++; if (res !== exp[i]) begin n_err++; $display("FAIL basic_data op=%0d: got %h expected %h", ops[i], res, exp[i]); end
            n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL basic_ovf op=%0d: got %b expected 0", ops[i], ovf); end
            n_vec++; if (lat != 3) begin n_err++; $display("FAIL basic_latency op=%0d: got %0d expected 3", ops[i], lat); end
            finish_rsp();
        end
    endtask

    task automatic test_sla_ovf();
        int lat; logic [7:0] res; logic ovf; bit to;
        send_req(8'h40, 4'd1, 2'd2, lat, res, ovf, to);
        n_vec++; if (res !== 8'h80 || to) begin n_err++; $display("FAIL sla40_data: got %h expected 80", res); end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL sla40_ovf: got %b expected 1", ovf); end
        finish_rsp();
        send_req(8'hF0, 4'd2, 2'd2, lat, res, ovf, to);
        n_vec++; if (res !== 8'hC0 || to) begin n_err++; $display("FAIL slaf0_data: got %h expected c0", res); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL slaf0_ovf: got %b expected 0", ovf); end
        finish_rsp();
        send_req(8'h40, 4'd1, 2'd2, lat, res, ovf, to);
        finish_rsp();
        send_req(8'h03, 4'd1, 2'd0, lat, res, ovf, to);
        n_vec++; if (res !== 8'h06 || to) begin n_err++; $display("FAIL sll_after_sla_data: got %h expected 06", res); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL sll_after_sla_ovf: got %b expected 0", ovf); end
        finish_rsp();
    endtask

    task automatic test_clip();
        int lat; logic [7:0] res; logic ovf; bit to;
        send_req(8'h96, 4'd12, 2'd3, lat, res, ovf, to);
        n_vec++; if (res !== 8'hFF || to) begin n_err++; $display("FAIL clip_sra_data: got %h expected ff", res); end
        n_vec++; if (lat != 9) begin n_err++; $display("FAIL clip_sra_latency: got %0d expected 9", lat); end
        finish_rsp();
        send_req(8'h96, 4'd15, 2'd1, lat, res, ovf, to);
        n_vec++; if (res !== 8'h00 || to) begin n_err++; $display("FAIL clip_srl_data: got %h expected 00", res); end
        n_vec++; if (lat != 9) begin n_err++; $display("FAIL clip_srl_latency: got %0d expected 9", lat); end
        finish_rsp();
    endtask

    task automatic test_zero_shift();
        int lat; logic [7:0] res; logic ovf; bit to;
        bus.out_ready = 1'b0;
        send_req(8'hA5, 4'd0, 2'd1, lat, res, ovf, to);
        n_vec++; if (res !== 8'hA5 || to) begin n_err++; $display("FAIL zero_data: got %h expected a5", res); end
        n_vec++; if (lat != 1) begin n_err++; $display("FAIL zero_latency: got %0d expected 1", lat); end
        for (int k = 0; k < 2; k++) begin
            n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL zero_in_ready: got %b expected 0", bus.in_ready); end
            @(negedge clk);
        end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] res; logic ovf; bit to; int g;
        bus.out_ready = 1'b0;
        send_req(8'h96, 4'd1, 2'd0, lat, res, ovf, to);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++; if (bus.out_data !== 8'h2C || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold: got data=%h valid=%b expected 2c/1", bus.out_data, bus.out_valid); end
            n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
        end
        bus.in_valid = 1'b1; bus.in_data = 8'h81; bus.in_shamt = 4'd1; bus.in_op = 2'd1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got ready=%b valid=%b expected 1/0", bus.in_ready, bus.out_valid); end
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept: got in_ready %b expected 0", bus.in_ready); end
        bus.in_valid = 1'b0;
        g = 0;
        while (!bus.out_valid && g < 20) begin @(negedge clk); g++; end
        n_vec++; if (bus.out_data !== 8'h40 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_data: got %h valid=%b expected 40/1", bus.out_data, bus.out_valid); end
        finish_rsp();
    endtask

    task automatic test_reset_mid();
        int lat; logic [7:0] res; logic ovf; bit to;
        bus.in_valid = 1'b1; bus.in_data = 8'h96; bus.in_shamt = 4'd8; bus.in_op = 2'd3;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_busy: got ready=%b valid=%b expected 0/0", bus.in_ready, bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b expected 0", bus.out_valid); end
        n_vec++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_data: got %h expected 00", bus.out_data); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b expected 1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_req(8'h01, 4'd3, 2'd0, lat, res, ovf, to);
        n_vec++; if (res !== 8'h08 || to) begin n_err++; $display("FAIL post_rst_data: got %h expected 08", res); end
        n_vec++; if (lat != 4) begin n_err++; $display("FAIL post_rst_latency: got %0d expected 4", lat); end
        finish_rsp();
    endtask

    task automatic test_random();
        int lat; logic [7:0] res; logic ovf; bit to;
        logic [7:0] d, er; logic [3:0] s; logic [1:0] op; logic eo; int bp, en;
        for (int it = 0; it < 120; it++) begin
            d  = 8'($urandom);
            s  = 4'($urandom_range(0, 15));
            op = 2'($urandom_range(0, 3));
            bp = $urandom_range(0, 3);
            ref_model(d, s, op, er, eo);
            en = (s > 4'd8) ? 8 : int'(s);
            bus.out_ready = (bp == 0);
            send_req(d, s, op, lat, res, ovf, to);
            n_vec++; if (res !== er || ovf !== eo || to) begin n_err++; $display("FAIL rand_result d=%h s=%0d op=%0d: got %h/%b expected %h/%b", d, s, op, res, ovf, er, eo); end
            n_vec++; if (lat != en + 1) begin n_err++; $display("FAIL rand_latency s=%0d: got %0d expected %0d", s, lat, en + 1); end
            for (int k = 0; k < bp; k++) begin
                @(negedge clk);
                n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== er || bus.out_ovf !== eo) begin n_err++; $display("FAIL rand_hold: got %b/%h/%b expected 1/%h/%b", bus.out_valid, bus.out_data, bus.out_ovf, er, eo); end
            end
            finish_rsp();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sla_ovf();
        test_clip();
        test_zero_shift();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_shift_unit.md
# serial_shift_unit

Multi-cycle shift execution stage that accepts an operand, a shift amount and a shift opcode over a valid/ready handshake. It performs one single-bit shift per clock and returns the result over a second valid/ready handshake. It sits between the operand-issue logic and result writeback. It is the sequential counterpart of the single-cycle combinational shift operators (SLL, SRL, SLA, SRA), for area-constrained datapaths.

## Interface
- WIDTH, default 8: operand and result width in bits, minimum 2.
- SHAMT_W, default $clog2(WIDTH)+1: shift-amount width. Amounts from 0 to 2^SHAMT_W-1 are legal.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a request is present on in_data/in_shamt/in_op.
- in_ready  output  1  the unit can accept a request; high only in IDLE.
- in_data  input  WIDTH  operand. Treated as two's-complement for SLA and SRA.
- in_shamt  input  SHAMT_W  requested shift amount.
- in_op  input  2  opcode: 00 SLL, 01 SRL, 10 SLA, 11 SRA.
- out_valid  output  1  the result is present; high only in DONE.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  working/result register.
- out_ovf  output  1  SLA sign-overflow flag; always 0 for the other opcodes.

## Operation
- Accept occurs on a clock edge with in_valid && in_ready. On accept, latch:
  - data into the working register,
  - op,
  - cnt = min(in_shamt, WIDTH).
- Clear ovf on accept.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on accept, go to SHIFT if cnt>0, otherwise go to DONE.
  - SHIFT: each cycle do one 1-bit shift and decrement cnt. Go to DONE on the cycle the last shift is done (cnt 1→0).
  - DONE: hold until out_ready=1, then go to IDLE.
- Per-step shift rules:
  - SLL and SLA: {w[WIDTH-2:0],1'b0}.
  - SRL: {1'b0,w[WIDTH-1:1]}.
  - SRA: {w[WIDTH-1],w[WIDTH-1:1]}.
- SLA overflow:
  - Before each SLA step, if w[WIDTH-1] != w[WIDTH-2], set ovf.
  - ovf is sticky until the next accept.
- Clipping: amounts ≥ WIDTH are clipped to WIDTH. The result is then all-zeros, or all sign bits for SRA. For SLA, ovf is set if any nonzero/non-sign bit passed through the MSB.
- No request overlap: a new request is accepted only in IDLE, never in the same cycle as a result handshake.
- out_data and out_ovf continuously drive the working register and flag. They are meaningful only while out_valid=1.
- in_data, in_shamt and in_op are don't-care outside an accept cycle.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0, cnt=0.
- Reset is asynchronous and takes effect immediately, including mid-SHIFT or in DONE. Any in-flight operation is discarded, with no partial result and no out_valid pulse.
- Latency: accept at edge T gives out_valid=1 from T+1+n, where n = min(shamt, WIDTH). n=0 gives out_valid at T+1.
- Minimum request period is n+2 cycles: accept, n shift cycles, DONE, then the IDLE cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_ovf and out_valid are held stable and in_ready=0.
- in_valid may be held high arbitrarily. Only one accept happens per IDLE visit.

## Test plan
- Basic shifts, WIDTH=8, in_data=0x96, shamt=2:
  - SLL→0x58, SRL→0x25, SRA→0xE5, each with out_ovf=0.
  - out_valid rises exactly 3 cycles after the accept edge.
- SLA overflow:
  - 0x40 shamt=1 → 0x80, out_ovf=1.
  - 0xF0 shamt=2 → 0xC0, out_ovf=0.
  - A following SLL request shows out_ovf=0.
- Clipping:
  - SRA 0x96 shamt=12 → 0xFF, with out_valid at T+9.
  - SRL 0x96 shamt=15 → 0x00.
- Zero shift: SRL 0xA5 shamt=0 → 0xA5, out_valid at T+1, in_ready low from T+1 until the result handshake.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE: out_data stays constant and in_ready=0 throughout.
  - Release out_ready with in_valid held high: the next request is accepted exactly one cycle after the result handshake.
- Reset mid-operation: assert rst_n=0 asynchronously during SHIFT of an 8-step SRA → immediately out_valid=0, out_data=0, in_ready=1. After release, a fresh SLL 0x01 shamt=3 returns 0x08.
